bitserial_addsub: RTL and testbench
===================================

# bitserial_addsub

- Bit-serial two's-complement adder/subtractor for the multicycle RISC datapath.
- Feeds one instance of the 1-bit full adder (`FA1b`) one operand bit pair per clock, LSB first, and registers its carry between cycles.
- Sits between the register-read stage and the result-writeback mux: it trades WIDTH cycles of latency for a single full-adder cell.
- Uses a start/done handshake and reports carry-out and signed overflow.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Legal range is 2 to 64.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `start`  in  1  request. Sampled high in IDLE or DONE, it launches an operation.
- `sub`  in  1  0 = a+b, 1 = a−b. Sampled with `start`.
- `a`  in  WIDTH  first operand. Sampled with `start`.
- `b`  in  WIDTH  second operand. Sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; the result outputs are valid from this cycle.
- `result`  out  WIDTH  sum or difference.
- `cout`  out  1  carry out of the MSB. When `sub`=1, `cout`=1 means no borrow.
- `ovf`  out  1  signed overflow: the carry into the MSB XOR the carry out of the MSB.
- `zero`  out  1  `result`==0. Present only with ZERO_FLAG_EN.

## Operation
- There are three states: IDLE, RUN and DONE.
- IDLE → RUN when `start`=1.
  - Load shift register `opa` from `a`.
  - Load shift register `opb` from `b` XOR {WIDTH{sub}}.
  - Set carry register = `sub`.
  - Set bit counter = 0.
- RUN, every edge:
  - `FA1b` inputs are `opa[0]`, `opb[0]` and the carry register.
  - Shift the sum bit into the MSB of the internal shift register `acc`.
  - Shift `opa` and `opb` right by one.
  - Carry register ← `FA1b` Cout.
  - Counter increments.
- RUN → DONE on the edge where counter = WIDTH−1. On that same edge:
  - `result` ← final `acc`, with the last sum bit included.
  - `cout` ← `FA1b` Cout.
  - `ovf` ← the carry register value (the carry into the MSB) XOR `FA1b` Cout.
- DONE lasts exactly one cycle, with `done`=1.
  - `start`=1 here → RUN (back-to-back operation).
  - Otherwise → IDLE.
- `start` is ignored while in RUN. The in-flight operation continues and its operands are unaffected.
- `result`, `cout`, `ovf` and `zero` are registered. They change only on the RUN→DONE edge and hold until the next completion. Partial sums never appear on them.
- Counter width is clog2(WIDTH). It does not wrap mid-operation; it returns to 0 on each launch.

## Timing
- Reset (`rst_n`=0, async): state = IDLE. All of the following are 0 immediately, without waiting for a clock edge:
  - outputs `busy`, `done`, `result`, `cout`, `ovf`;
  - internal registers `opa`, `opb`, `acc`, carry and counter;
  - `zero` (when ZERO_FLAG_EN is defined).
- Reset mid-RUN aborts the operation. `done` is never asserted for the aborted operation.
- Take edge E0 as the edge where `start` is sampled.
  - `busy`=1 during cycles E0..E(WIDTH).
  - `done`=1 during cycle E(WIDTH)..E(WIDTH+1).
  - Latency is WIDTH+1 edges from start to the `done` pulse.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles. `busy` rises again on the DONE-exit edge.
- The `FA1b` path is purely combinational. Its only registered feedback is the carry register, so there is no combinational path from any input port to any output port.

## Configuration
- Macro: `BITSERIAL_ADDSUB_ZERO_FLAG_EN`.
- Defined:
  - `zero` port exists.
  - It is registered on the RUN→DONE edge as (final `acc` == 0).
  - It holds alongside `result` and resets to 0.
- Undefined:
  - `zero` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- `a`=0x7F, `b`=0x01, `sub`=0 → `result`=0x80, `cout`=0, `ovf`=1. `done` pulses exactly 9 edges after `start`.
- `a`=0xFF, `b`=0x01, `sub`=0 → `result`=0x00, `cout`=1, `ovf`=0. `zero`=1 when the macro is defined.
- `a`=0x05, `b`=0x07, `sub`=1 → `result`=0xFE, `cout`=0 (borrow), `ovf`=0. Then `a`=0x80, `b`=0x01, `sub`=1 → `result`=0x7F, `ovf`=1.
- Start 0x10+0x20, then pulse `start` with 0x01+0x01 at cycle 3 of RUN → only `result`=0x30 is produced. No second `done`.
- Hold `start`=1 continuously with 0x03+0x04 → `done` every 9 cycles, `result`=0x07 each time, `busy` low only during the DONE cycles.
- Assert `rst_n`=0 at cycle 4 of RUN → all outputs are 0 immediately, with no `done`. After release, 0x02+0x02 yields 0x04.

Source files
------------

// File: rtl/bitserial_addsub.sv
// ---------------------------------------------------------------------------
// bitserial_addsub
//   Two's-complement adder/subtractor that pushes one operand bit pair per
//   clock through a single 1-bit full adder (FA1b), LSB first, keeping only
//   the carry as registered feedback between cycles.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   launch request, honoured in IDLE or DONE, ignored in RUN
//   sub     0: a+b, 1: a-b (sampled with start)
//   a, b    WIDTH-bit operands (sampled with start)
//   busy    high while the serial add is in progress
//   done    one-cycle pulse; result/cout/ovf(/zero) valid from this cycle
//   result  registered sum or difference
//   cout    carry out of the MSB (for subtract, 1 means no borrow)
//   ovf     signed overflow: carry into MSB XOR carry out of MSB
//   zero    result == 0 (only when BITSERIAL_ADDSUB_ZERO_FLAG_EN is defined)
//
// Build option
//   BITSERIAL_ADDSUB_ZERO_FLAG_EN : adds the registered zero flag output.
// ---------------------------------------------------------------------------

// Purpose: bit-serial add/sub, one full-adder cell reused for WIDTH cycles.
// Latency: WIDTH+1 edges from start sample to done pulse; one result per WIDTH+1 cycles.
// Backpressure: none; start is only accepted in IDLE/DONE and ignored while busy.
module bitserial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
            $error("bitserial_addsub: WIDTH must be in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_co;
    logic             launch;
    logic             last_bit;
    logic [WIDTH-1:0] acc_final;

    // The only arithmetic cell; its carry is closed through the carry register.
    FA1b u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_co)
    );

    // Accumulator as it will look after the current edge, with the last
    // sum bit already shifted into the MSB.
    assign acc_final = {fa_sum, acc[WIDTH-1:1]};

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        last_bit  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A start seen here chains straight into the next operation.
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Serial datapath: operand shifters, carry, bit counter, accumulator
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (launch) begin
            opa   <= a;
            // Subtract as a + ~b + 1: invert b here and seed carry with sub.
            opb   <= b ^ {WIDTH{sub}};
            acc   <= '0;
            carry <= sub;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            acc   <= acc_final;
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= fa_co;
            cnt   <= cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Result registers: updated only on the final RUN edge so partial sums
    // never reach the outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (last_bit) begin
            result <= acc_final;
            cout   <= fa_co;
            // carry currently holds the carry into the MSB position.
            ovf    <= carry ^ fa_co;
        end
    end

`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (last_bit) begin
            zero <= (acc_final == '0);
        end
    end
`endif

endmodule

// Purpose: 1-bit full adder cell.
// Latency: purely combinational.
// Backpressure: none.
module FA1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: tb/tb_bitserial_addsub.sv
// Self-checking bench for bitserial_addsub at WIDTH=8.
module tb_bitserial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;

    bitserial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned sum/difference, borrow-based carry, signed range test.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] mres, output logic mco, output logic mov);
        int ua, ub, sa, sb, sr, ur;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (msub) begin
            ur  = ua - ub;
            sr  = sa - sb;
            mco = (ua >= ub);
        end else begin
            ur  = ua + ub;
            sr  = sa + sb;
            mco = (ur > 255);
        end
        mres = W'(ur & 255);
        mov  = (sr > 127) || (sr < -128);
    endtask

    // Launch one op from IDLE, wait (bounded) for done, check latency and
    // that result holds its previous value until completion.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          output logic [W-1:0] r, output logic co, output logic ov);
        logic [W-1:0] prev;
        int lat;
        prev = result;
        @(negedge clk);
        a = ta; b = tb; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the ports: the in-flight operation must not see them.
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        lat = 1;
        check("busy_after_start", busy, 1'b1);
        while (!done && lat < 40) begin
            check("result_hold", result, prev);
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", lat, W + 1);
        check("busy_in_done", busy, 1'b0);
        r  = result;
        co = cout;
        ov = ovf;
`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
        check("zero_flag", zero, (result == '0));
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("result_held", result, r);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] r, er;
        logic co, ov, eco, eov;
        int ndone;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, r, co, ov);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
            check($sformatf("vec%0d_cout", i), co, vecs[i].exp_cout);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
        end

        // Random against the model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            model(ra, rb, rs, er, eco, eov);
            run_op(ra, rb, rs, r, co, ov);
            check("rand_result", r, er);
            check("rand_cout", co, eco);
            check("rand_ovf", ov, eov);
        end

        // start pulsed during RUN is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int j = 0; j < 25; j++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("ignore_result", result, 8'h30);
            end
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_idle_busy", busy, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
        for (int j = 0; j < 27; j++) begin
            @(posedge clk); #1;
            check("b2b_done", done, (j % 9) == 8);
            check("b2b_busy", busy, (j % 9) != 8);
            if (done) check("b2b_result", result, 8'h07);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_busy", busy, 1'b0);
        check("b2b_end_done", done, 1'b0);

        // Reset in the middle of RUN
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 8'h00);
        check("midrst_cout", cout, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
`ifdef BITSERIAL_ADDSUB_ZERO_FLAG_EN
        check("midrst_zero", zero, 1'b0);
`endif
        ndone = 0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("post_rst_quiet", ndone, 0);
        run_op(8'h02, 8'h02, 1'b0, r, co, ov);
        check("post_rst_result", r, 8'h04);
        check("post_rst_cout", co, 1'b0);
        check("post_rst_ovf", ov, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
